// File: rtl/matrix_engine_pkg.sv
// Shared constants and types for the matrix engine blocks.
// Module-select codes, source-matrix presets and the memory fill-sequencer state type.
package matrix_engine_pkg;

    localparam logic [3:0] INSTR_EN = 4'h0;
    localparam logic [3:0] MEM_EN   = 4'h1;
    localparam logic [3:0] ALU_EN   = 4'h2;
    localparam logic [3:0] EXE_EN   = 4'h3;
    localparam logic [3:0] REG_EN   = 4'h4;

    localparam logic [255:0] MAT_A_PRESET =
        256'h0004_000c_0004_0022_0007_0006_000b_0009_0009_0002_0008_000d_0002_000f_0010_0003;
    localparam logic [255:0] MAT_B_PRESET =
        256'h0017_002d_001f_0016_0007_0006_0004_0001_0012_000c_000d_000c_000d_0005_0007_0013;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        CLEAR = 2'd2
    } fill_state_e;

endpackage

// File: rtl/mem_fill_sequencer.sv
// Walks every word of the bank once after reset (preset load) or on a clear request (zero fill).
// Owns the busy/ready state and supplies the fill address and data for each cycle.
module mem_fill_sequencer
    import matrix_engine_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned DEPTH     = 16,
    parameter bit          PRESET_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_clear,
    output logic              ready,
    output logic              fill_we,
    output logic [3:0]        fill_addr,
    output logic [DATA_W-1:0] fill_data
);

    localparam logic [3:0] LAST = 4'(DEPTH - 1);

    fill_state_e state;
    logic [3:0]  ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            ptr   <= 4'd0;
        end else begin
            case (state)
                INIT, CLEAR: begin
                    if (ptr == LAST) begin
                        ptr   <= 4'd0;
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + 4'd1;
                    end
                end
                IDLE: begin
                    if (start_clear) begin
                        ptr   <= 4'd0;
                        state <= CLEAR;
                    end
                end
                default: begin
                    ptr   <= 4'd0;
                    state <= INIT;
                end
            endcase
        end
    end

    assign ready     = (state == IDLE);
    // Suppressed while reset is held so an aborted clear cannot touch the array.
    assign fill_we   = (state != IDLE) & ~reset;
    assign fill_addr = ptr;

    always_comb begin
        fill_data = '0;
        if (PRESET_EN && state == INIT) begin
            if (ptr == 4'd0) begin
                fill_data = DATA_W'(MAT_A_PRESET);
            end else if (ptr == 4'd1) begin
                fill_data = DATA_W'(MAT_B_PRESET);
            end
        end
    end

endmodule

// File: rtl/matrix_memory_bank.sv
// Word-addressed data memory on the shared address bus with lane-masked writes,
// registered read flags and a held tri-state read bus.
module matrix_memory_bank
    import matrix_engine_pkg::*;
#(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned LANE_W    = 16,
    parameter int unsigned DEPTH     = 16,
    parameter logic [3:0]  MODULE_ID = MEM_EN,
    parameter bit          PRESET_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              addressBus,
    input  logic [DATA_W-1:0]        inputDataBus,
    input  logic                     writeToMem,
    input  logic                     readFromMem,
    input  logic [DATA_W/LANE_W-1:0] laneMask,
    input  logic                     clearMem,
    inout  wire  [DATA_W-1:0]        outputDataBus,
    output logic                     ready,
    output logic                     readValid,
    output logic                     addrError
);

    localparam int unsigned LANES = DATA_W / LANE_W;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0]  DEPTH_W5 = 5'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] outputRegister;
    logic              driveTheBus;

    logic              fill_we;
    logic [3:0]        fill_addr;
    logic [DATA_W-1:0] fill_data;

    mem_fill_sequencer #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .PRESET_EN (PRESET_EN)
    ) u_fill (
        .clk         (clk),
        .reset       (reset),
        .start_clear (clearMem),
        .ready       (ready),
        .fill_we     (fill_we),
        .fill_addr   (fill_addr),
        .fill_data   (fill_data)
    );

    logic [3:0]    wa;
    logic [AW-1:0] wa_idx;
    logic [AW-1:0] fill_idx;
    logic          sel, in_range, any_cmd, cmd_ok;
    logic          do_read, do_write, bad_addr, foreign, do_clear;
    logic          unused_addr;

    assign wa          = addressBus[7:4];
    assign wa_idx      = wa[AW-1:0];
    assign fill_idx    = fill_addr[AW-1:0];
    assign unused_addr = ^{addressBus[11:8], addressBus[3:0]};

    assign sel      = (addressBus[15:12] == MODULE_ID);
    assign in_range = ({1'b0, wa} < DEPTH_W5);
    assign any_cmd  = readFromMem | writeToMem;
    // Clear outranks read/write; nothing is accepted outside IDLE or under reset.
    assign cmd_ok   = ready & ~clearMem & ~reset;
    assign do_clear = ready & clearMem & ~reset;
    assign do_read  = cmd_ok & sel & readFromMem & in_range;
    assign do_write = cmd_ok & sel & writeToMem & in_range;
    assign bad_addr = cmd_ok & sel & any_cmd & ~in_range;
    assign foreign  = cmd_ok & ~sel & any_cmd;

    always_comb begin
        merged = mem[wa_idx];
        for (int i = 0; i < LANES; i++) begin
            if (laneMask[i]) begin
                merged[i*LANE_W +: LANE_W] = inputDataBus[i*LANE_W +: LANE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[fill_idx] <= fill_data;
        end else if (do_write) begin
            mem[wa_idx] <= merged;
        end
    end

    // Read-before-write: a same-cycle read captures the pre-write word but loses the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            outputRegister <= '0;
            driveTheBus    <= 1'b0;
            readValid      <= 1'b0;
            addrError      <= 1'b0;
        end else begin
            readValid <= do_read & ~do_write;
            addrError <= bad_addr;
            if (do_read) begin
                outputRegister <= mem[wa_idx];
            end
            if (do_write | do_clear | foreign) begin
                driveTheBus <= 1'b0;
            end else if (do_read) begin
                driveTheBus <= 1'b1;
            end
        end
    end

    assign outputDataBus = driveTheBus ? outputRegister : {DATA_W{1'bz}};

endmodule

// File: tb/tb_matrix_memory_bank.sv
// Bench for matrix_memory_bank: a per-cycle reference model for the default build plus
// directed checks, and a DEPTH=4 build for out-of-range handling.
module tb_matrix_memory_bank;

    localparam int unsigned DW = 256;
    localparam int unsigned NL = 16;
    localparam int unsigned MD = 16;
    localparam logic [DW-1:0] MA = matrix_engine_pkg::MAT_A_PRESET;
    localparam logic [DW-1:0] MB = matrix_engine_pkg::MAT_B_PRESET;
    // Pulled-up bus: a released bus reads as all ones.
    localparam logic [DW-1:0] REL = '1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [15:0]   addr;
    logic [DW-1:0] din;
    logic          wr, rd, clr;
    logic [NL-1:0] mask;
    tri1  [DW-1:0] bus;
    logic          ready, rv, ae;

    logic [15:0]   s_addr;
    logic [DW-1:0] s_din;
    logic          s_wr, s_rd, s_clr;
    logic [NL-1:0] s_mask;
    tri1  [DW-1:0] s_bus;
    logic          s_ready, s_rv, s_ae;

    matrix_memory_bank dut (
        .clk           (clk),
        .reset         (reset),
        .addressBus    (addr),
        .inputDataBus  (din),
        .writeToMem    (wr),
        .readFromMem   (rd),
        .laneMask      (mask),
        .clearMem      (clr),
        .outputDataBus (bus),
        .ready         (ready),
        .readValid     (rv),
        .addrError     (ae)
    );

    matrix_memory_bank #(
        .DEPTH (4)
    ) dut_small (
        .clk           (clk),
        .reset         (reset),
        .addressBus    (s_addr),
        .inputDataBus  (s_din),
        .writeToMem    (s_wr),
        .readFromMem   (s_rd),
        .laneMask      (s_mask),
        .clearMem      (s_clr),
        .outputDataBus (s_bus),
        .ready         (s_ready),
        .readValid     (s_rv),
        .addrError     (s_ae)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: whole-memory effects applied at once, busy time as a countdown.
    logic [DW-1:0] m_mem [MD];
    int            m_busy = 0;
    logic [DW-1:0] m_out = '0;
    bit            m_drive = 0, m_rv = 0, m_ae = 0, m_live = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1;
            m_busy = MD;
            foreach (m_mem[i]) m_mem[i] = '0;
            m_mem[0] = MA;
            m_mem[1] = MB;
            m_out = '0;
            m_drive = 0;
            m_rv = 0;
            m_ae = 0;
        end else if (m_live) begin
            m_rv = 0;
            m_ae = 0;
            if (m_busy > 0) begin
                m_busy--;
            end else if (clr) begin
                m_busy = MD;
                foreach (m_mem[i]) m_mem[i] = '0;
                m_drive = 0;
            end else if (rd || wr) begin
                if (addr[15:12] != 4'h1) begin
                    m_drive = 0;
                end else if (int'(addr[7:4]) >= int'(MD)) begin
                    m_ae = 1;
                end else begin
                    if (rd) m_out = m_mem[addr[7:4]];
                    if (wr) begin
                        for (int l = 0; l < NL; l++) begin
                            if (mask[l]) m_mem[addr[7:4]][l*16 +: 16] = din[l*16 +: 16];
                        end
                        m_drive = 0;
                    end else begin
                        m_drive = 1;
                        m_rv = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("ready", DW'(ready), DW'(m_busy == 0));
            chk("readValid", DW'(rv), DW'(m_rv));
            chk("addrError", DW'(ae), DW'(m_ae));
            chk("bus", bus, m_drive ? m_out : REL);
        end
    end

    task automatic set_idle();
        addr = '0; din = '0; wr = 0; rd = 0; clr = 0; mask = '0;
    endtask

    task automatic s_idle();
        s_addr = '0; s_din = '0; s_wr = 0; s_rd = 0; s_clr = 0; s_mask = '0;
    endtask

    task automatic issue(input logic [15:0] a, input bit r, input bit w, input bit c,
                         input logic [DW-1:0] d, input logic [NL-1:0] m);
        addr = a; rd = r; wr = w; clr = c; din = d; mask = m;
        @(negedge clk);
        set_idle();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    logic [DW-1:0] s_exp [4];

    initial begin
        int n;
        set_idle();
        s_idle();
        reset = 1;
        @(negedge clk);
        reset = 0;

        wait_ready(n);
        chk("init_busy_cycles", DW'(n), DW'(16));

        // Preset reads
        issue(16'h1000, 1, 0, 0, '0, '0);
        chk("rd0_valid", DW'(rv), DW'(1));
        chk("rd0_word", bus, MA);
        chk("rd0_lane0", DW'(bus[15:0]), DW'(16'h0003));
        issue(16'h1010, 1, 0, 0, '0, '0);
        chk("rd1_lane0", DW'(bus[15:0]), DW'(16'h0013));
        chk("rd1_lane15", DW'(bus[255:240]), DW'(16'h0017));

        // Lane-masked write
        issue(16'h1020, 0, 1, 0, '1, 16'h0005);
        chk("wr_bus_released", bus, REL);
        chk("wr_no_valid", DW'(rv), DW'(0));
        issue(16'h1020, 1, 0, 0, '0, '0);
        chk("mask_word", bus, 256'hFFFF_0000_FFFF);

        // Held read, then another module takes the bus
        issue(16'h1000, 1, 0, 0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_bus", bus, MA);
            chk("hold_no_valid", DW'(rv), DW'(0));
        end
        issue(16'h4000, 1, 0, 0, '0, '0);
        chk("foreign_release", bus, REL);
        chk("foreign_no_valid", DW'(rv), DW'(0));

        // Same-cycle read and write
        issue(16'h1010, 1, 1, 0, {16{16'hAAAA}}, '1);
        chk("rw_no_valid", DW'(rv), DW'(0));
        chk("rw_bus_released", bus, REL);
        issue(16'h1010, 1, 0, 0, '0, '0);
        chk("rw_new_data", bus, {16{16'hAAAA}});

        // DEPTH=4 build: out-of-range access
        chk("small_ready", DW'(s_ready), DW'(1));
        s_addr = 16'h1050; s_wr = 1; s_din = '1; s_mask = '1;
        @(negedge clk);
        s_idle();
        chk("small_oor_err", DW'(s_ae), DW'(1));
        chk("small_oor_ready", DW'(s_ready), DW'(1));
        chk("small_oor_no_valid", DW'(s_rv), DW'(0));
        @(negedge clk);
        chk("small_err_pulse", DW'(s_ae), DW'(0));
        s_exp[0] = MA; s_exp[1] = MB; s_exp[2] = '0; s_exp[3] = '0;
        for (int w = 0; w < 4; w++) begin
            s_addr = {4'h1, 4'h0, 4'(w), 4'h0};
            s_rd = 1;
            @(negedge clk);
            s_idle();
            chk("small_rd_valid", DW'(s_rv), DW'(1));
            chk("small_rd_word", s_bus, s_exp[w]);
        end
        s_addr = 16'h1070; s_rd = 1;
        @(negedge clk);
        s_idle();
        chk("small_oor_rd_err", DW'(s_ae), DW'(1));
        chk("small_oor_rd_valid", DW'(s_rv), DW'(0));

        // Clear with a write attempted mid-clear
        issue(16'h0000, 0, 0, 1, '0, '0);
        n = 0;
        while (!ready && n < 64) begin
            if (n == 3) begin
                addr = 16'h1000; wr = 1; din = {16{16'h1234}}; mask = '1;
            end else begin
                set_idle();
            end
            n++;
            @(negedge clk);
        end
        set_idle();
        chk("clear_busy_cycles", DW'(n), DW'(16));
        issue(16'h1000, 1, 0, 0, '0, '0);
        chk("clear_word0", bus, '0);
        issue(16'h1010, 1, 0, 0, '0, '0);
        chk("clear_word1", bus, '0);

        // Reset during a clear restarts the preset load
        issue(16'h0000, 0, 0, 1, '0, '0);
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        wait_ready(n);
        chk("reinit_busy_cycles", DW'(n), DW'(16));
        issue(16'h1000, 1, 0, 0, '0, '0);
        chk("reinit_word0", bus, MA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/matrix_memory_bank.md
Name: matrix_memory_bank

Overview:
- Parametrised successor to the matrix engine's data memory: a DEPTH x DATA_W word store on the shared 16-bit address bus, selected by module field addressBus[15:12] == MODULE_ID.
- Adds a synchronous reset-driven preset/clear sequencer, lane-masked writes, a ready/valid handshake, out-of-range detection, and a held tri-state read bus.
- Sits between the EXE controller (commands) and the ALU/register file (data).

Parameters:
- DATA_W, 256, word width; must be a multiple of LANE_W.
- LANE_W, 16, write-mask granularity (one matrix element).
- DEPTH, 16, number of words; 2..16.
- MODULE_ID, 4'h1, value of addressBus[15:12] that selects this block.
- PRESET_EN, 1, when 1 the init sequence loads the two source matrices into words 0 and 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addressBus  in  16  [15:12] module select, [7:4] word address; other bits ignored
- inputDataBus  in  DATA_W  write data
- writeToMem  in  1  write command
- readFromMem  in  1  read command
- laneMask  in  DATA_W/LANE_W  per-lane write enable; bit i covers bits [i*LANE_W +: LANE_W]
- clearMem  in  1  start a zero-fill of all words
- outputDataBus  inout  DATA_W  read data; driven only while driveTheBus=1, else Z
- ready  out  1  block accepts commands (IDLE)
- readValid  out  1  one-cycle pulse: new read data is on the bus
- addrError  out  1  one-cycle pulse: selected access with word address >= DEPTH

Behaviour:
- Reset (sampled on posedge clk while reset=1):
  - state=INIT, initialisation pointer=0.
  - ready=0, readValid=0, addrError=0, driveTheBus=0, outputRegister=0.
  - Reset asserted mid-operation (INIT, CLEAR, or a held read) aborts it and restarts INIT.
- States:
  - INIT: writes one word per cycle at the pointer.
    - If PRESET_EN: word 0 = MAT_A_PRESET, word 1 = MAT_B_PRESET, all others = 0.
    - Otherwise all words = 0.
    - Pointer wraps at DEPTH-1 -> IDLE. INIT lasts exactly DEPTH cycles after reset deasserts.
  - IDLE: ready=1; commands are accepted only here.
  - CLEAR: entered from IDLE on clearMem=1 (no module select needed).
    - Zeros one word per cycle for DEPTH cycles, no presets, then -> IDLE.
    - driveTheBus=0 on entry.
- Command decode in IDLE. sel = (addressBus[15:12]==MODULE_ID); wa = addressBus[7:4].
  - Any command issued while ready=0 is dropped silently, with no flags raised.
  - clearMem has priority over read/write in the same cycle; the read/write is dropped.
- Read (sel & readFromMem & wa<DEPTH):
  - outputRegister <= mem[wa] at the posedge.
  - driveTheBus=1 and readValid=1 in the following cycle (latency 1).
  - The bus stays driven until one of: an accepted write, a clear, reset, or a cycle where readFromMem|writeToMem is asserted with sel=0 (another module owns the bus).
- Write (sel & writeToMem & wa<DEPTH):
  - Each lane with laneMask[i]=1 is updated from inputDataBus; other lanes keep their value.
  - driveTheBus<=0.
- Simultaneous read and write, same address:
  - Read-before-write: outputRegister gets pre-write data and the mask-merged write commits.
  - The write wins bus ownership, so driveTheBus=0 and readValid=0.
- Out of range (sel & (read|write) & wa>=DEPTH):
  - No memory change, addrError pulses 1 cycle.
  - driveTheBus and outputRegister are unchanged.
- readValid and addrError are registered and are never high together.
- No write-through: a read issued one cycle after a write to the same address returns the new data.

Decomposition:
- Shared package matrix_engine_pkg holds:
  - module enable constants INSTR_EN=4'h0, MEM_EN=4'h1, ALU_EN=4'h2, EXE_EN=4'h3, REG_EN=4'h4;
  - 256-bit constants MAT_A_PRESET = 0x0004_000c_0004_0022_0007_0006_000b_0009_0009_0002_0008_000d_0002_000f_0010_0003 and MAT_B_PRESET = 0x0017_002d_001f_0016_0007_0006_0004_0001_0012_000c_000d_000c_000d_0005_0007_0013;
  - the state enum {INIT, IDLE, CLEAR}.
- One sub-module, mem_fill_sequencer: owns the pointer counter, the INIT/CLEAR state, the ready output, and the per-cycle fill word/address.
- The top level holds the storage array, lane-merge logic, command decode, and bus driver.

Test Plan:
- Reset 1 cycle, then wait -> ready=0 for exactly 16 cycles then 1; outputDataBus=Z throughout; read addr 16'h1000 -> readValid next cycle, bus = MAT_A_PRESET (lane0=0x0003); read 16'h1010 -> lane0=0x0013.
- Write 16'h1020, data all 0xFFFF lanes, laneMask=16'h0005; then read 16'h1020 -> lanes 0 and 2 = 0xFFFF, all others 0x0000; bus went Z during the write cycle.
- Read 16'h1000, then idle 3 cycles -> bus holds MAT_A_PRESET all 3 cycles; then readFromMem with addressBus=16'h4000 -> bus Z next cycle and readValid stays 0.
- DEPTH=4 build: write 16'h1050 -> addrError 1-cycle pulse, ready stays 1; reading words 0..3 afterwards shows no change.
- Same-cycle read and write to 16'h1010 with data 0x...AAAA, full mask -> readValid=0, bus Z; the next read returns 0xAAAA in all lanes.
- clearMem in IDLE -> ready=0 for 16 cycles; a write issued during the clear is ignored; then word0 reads 0. Reset asserted on clear cycle 5 -> INIT restarts and word0 reads MAT_A_PRESET afterwards.
